// File: rtl/out_arb_pkg.sv
// Shared types and default sizing for the output-port arbiter.
package out_arb_pkg;

  localparam int unsigned NREQ_DEF = 10;
  localparam int unsigned SELW_DEF = 4;
  localparam int unsigned TMO_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/out_arb_rr_pick.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping to 0.
module out_arb_rr_pick
  import out_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned SELW = SELW_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] pick_c,
  output logic            any_c
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    pick_c = '0;
    any_c  = |req;
    idx    = 0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % NREQ;
      if (|(req & (NREQ'(1) << idx))) begin
        pick_c = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/out_arb.sv
// Output-port arbiter: round-robin grant with packet-level lock, tail or
// drop release, inactivity timeout and protocol-error pulse.
module out_arb
  import out_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned SELW = SELW_DEF,
  parameter int unsigned TMO  = TMO_DEF
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] vld,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] grt,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            err
);

  localparam int unsigned CNTW = (TMO > 1) ? $clog2(TMO) : 1;

  state_e          state_q, state_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] grt_d;
  logic [SELW-1:0] sel_d;
  logic            busy_d, err_d;

  logic [SELW-1:0] pick_c;
  logic            any_c;
  logic            owner_vld_c, owner_req_c, owner_last_c;
  logic            rel_tail_c, rel_drop_c, rel_tmo_c;

  out_arb_rr_pick #(
    .NREQ (NREQ),
    .SELW (SELW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .pick_c (pick_c),
    .any_c  (any_c)
  );

  // Owner-side views of the request/flit lines and the three release causes.
  always_comb begin
    owner_vld_c  = |(vld & grt);
    owner_req_c  = |(req & grt);
    owner_last_c = |(vld & last & grt);
    rel_tail_c   = owner_last_c;
    rel_drop_c   = ~owner_req_c;
    rel_tmo_c    = ~owner_vld_c && (cnt_q == CNTW'(TMO - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    grt_d    = grt;
    sel_d    = sel;
    busy_d   = busy;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = |vld;
        if (any_c) begin
          state_d = HOLD;
          grt_d   = NREQ'(1) << pick_c;
          sel_d   = pick_c;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        err_d = |(vld & ~grt);
        if (rel_tail_c || rel_drop_c || rel_tmo_c) begin
          state_d  = IDLE;
          grt_d    = '0;
          sel_d    = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          rr_ptr_d = (sel == SELW'(NREQ - 1)) ? '0 : sel + SELW'(1);
          // A timeout only counts as a violation when no clean release coincides.
          if (rel_tmo_c && !rel_drop_c) begin
            err_d = 1'b1;
          end
        end else if (owner_vld_c) begin
          cnt_d = '0;
        end else if (cnt_q != CNTW'(TMO - 1)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      grt      <= grt_d;
      sel      <= sel_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_out_arb.sv
// Directed plus random bench for out_arb with a behavioural scoreboard.
module tb_out_arb;

  localparam int unsigned N  = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned T  = 16;

  logic          clk = 1'b0;
  logic          rst_;
  logic [N-1:0]  req, vld, last;
  logic [N-1:0]  grt;
  logic [SW-1:0] sel;
  logic          busy, err;

  typedef struct packed {
    logic [N-1:0]  grt;
    logic [SW-1:0] sel;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_owner = -1;
  int   m_ptr = 0;
  int   m_cnt = 0;

  out_arb dut (
    .clk  (clk),
    .rst_ (rst_),
    .req  (req),
    .vld  (vld),
    .last (last),
    .grt  (grt),
    .sel  (sel),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return |(v & (N'(1) << i));
  endfunction

  // Reference behaviour: compute what the outputs must be after the coming edge.
  task automatic model_push();
    exp_t e;
    bit   m_err;
    bit   tail, drop, tmo, found;
    int   idx;
    m_err = 1'b0;
    if (!rst_) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      m_err = |vld;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && bit_of(req, idx)) begin
          m_owner = idx;
          m_cnt   = 0;
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i != m_owner && bit_of(vld, i)) m_err = 1'b1;
      end
      tail = bit_of(vld, m_owner) && bit_of(last, m_owner);
      drop = !bit_of(req, m_owner);
      tmo  = !bit_of(vld, m_owner) && (m_cnt == T - 1);
      if (tail || drop || tmo) begin
        if (tmo && !drop) m_err = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (bit_of(vld, m_owner)) begin
        m_cnt = 0;
      end else if (m_cnt < T - 1) begin
        m_cnt++;
      end
    end
    e.grt  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.sel  = (m_owner < 0) ? '0 : SW'(m_owner);
    e.busy = (m_owner >= 0);
    e.err  = m_err;
    sbq.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty got %0d entries exp >0", sbq.size());
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checks++;
      assert (grt === e.grt) else begin
        errors++;
        $error("FAIL sb_grt got %b exp %b", grt, e.grt);
      end
      checks++;
      assert (sel === e.sel) else begin
        errors++;
        $error("FAIL sb_sel got %0d exp %0d", sel, e.sel);
      end
      checks++;
      assert (busy === e.busy) else begin
        errors++;
        $error("FAIL sb_busy got %b exp %b", busy, e.busy);
      end
      checks++;
      assert (err === e.err) else begin
        errors++;
        $error("FAIL sb_err got %b exp %b", err, e.err);
      end
    end
  endtask

  // One clock: drive inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] vl,
                     input logic [N-1:0] ls);
    rst_ = r;
    req  = rq;
    vld  = vl;
    last = ls;
    model_push();
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  // Directed literal check at a key point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [N-1:0] rq, vl, ls;
    logic         r;

    // Reset
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    chk("rst_grt", 32'(grt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Single requester 2
    cyc(1'b1, 10'b0000000100, '0, '0);
    chk("g2_grt", 32'(grt), 32'b0000000100);
    chk("g2_sel", 32'(sel), 32'd2);
    chk("g2_busy", 32'(busy), 32'h1);

    // Lock held while 3 also requests, released by tail of 2
    repeat (3) cyc(1'b1, 10'b0000001100, '0, '0);
    chk("lock_grt", 32'(grt), 32'b0000000100);
    cyc(1'b1, 10'b0000001100, 10'b0000000100, 10'b0000000100);
    chk("tail_rel_grt", 32'(grt), 32'h0);
    chk("tail_rel_err", 32'(err), 32'h0);
    cyc(1'b1, 10'b0000001000, '0, '0);
    chk("g3_grt", 32'(grt), 32'b0000001000);
    chk("g3_sel", 32'(sel), 32'd3);
    cyc(1'b1, '0, '0, '0);
    chk("drop_rel_err", 32'(err), 32'h0);

    // Steer pointer to 9, then wrap to 0
    cyc(1'b1, 10'b0100000000, '0, '0);
    cyc(1'b1, '0, '0, '0);
    cyc(1'b1, 10'b1000000001, '0, '0);
    chk("g9_sel", 32'(sel), 32'd9);
    cyc(1'b1, 10'b1000000001, 10'b1000000000, 10'b1000000000);
    cyc(1'b1, 10'b1000000001, '0, '0);
    chk("wrap_sel", 32'(sel), 32'd0);
    chk("wrap_grt", 32'(grt), 32'b0000000001);
    cyc(1'b1, '0, '0, '0);

    // Timeout on owner 4
    cyc(1'b1, 10'b0000010000, '0, '0);
    repeat (T - 1) cyc(1'b1, 10'b0000010000, '0, '0);
    chk("tmo_hold_grt", 32'(grt), 32'b0000010000);
    cyc(1'b1, 10'b0000010000, '0, '0);
    chk("tmo_grt", 32'(grt), 32'h0);
    chk("tmo_err", 32'(err), 32'h1);
    cyc(1'b1, '0, '0, '0);
    chk("tmo_err_pulse", 32'(err), 32'h0);

    // Owner activity restarts the idle count; drop coinciding with timeout
    cyc(1'b1, 10'b0000010000, '0, '0);
    repeat (10) cyc(1'b1, 10'b0000010000, '0, '0);
    cyc(1'b1, 10'b0000010000, 10'b0000010000, '0);
    repeat (T - 1) cyc(1'b1, 10'b0000010000, '0, '0);
    chk("restart_grt", 32'(grt), 32'b0000010000);
    cyc(1'b1, '0, '0, '0);
    chk("drop_tmo_busy", 32'(busy), 32'h0);
    chk("drop_tmo_err", 32'(err), 32'h0);

    // Foreign flit while owner 1 holds
    cyc(1'b1, 10'b0000000010, '0, '0);
    cyc(1'b1, 10'b0000000010, 10'b0000100000, '0);
    chk("foreign_err", 32'(err), 32'h1);
    chk("foreign_grt", 32'(grt), 32'b0000000010);
    cyc(1'b1, 10'b0000000010, '0, '0);
    chk("foreign_err_clr", 32'(err), 32'h0);
    cyc(1'b1, 10'b0000000010, 10'b0000000010, 10'b0000000010);

    // Flit while idle
    cyc(1'b1, '0, 10'b0000000001, '0);
    chk("idle_vld_err", 32'(err), 32'h1);

    // Fairness: re-requesting owner yields to a waiting requester
    cyc(1'b1, 10'b0000001000, '0, '0);
    cyc(1'b1, 10'b0001001000, 10'b0000001000, 10'b0000001000);
    cyc(1'b1, 10'b0001001000, '0, '0);
    chk("fair_sel6", 32'(sel), 32'd6);
    cyc(1'b1, 10'b0001001000, 10'b0001000000, 10'b0001000000);
    cyc(1'b1, 10'b0001001000, '0, '0);
    chk("fair_sel3", 32'(sel), 32'd3);
    cyc(1'b1, '0, '0, '0);

    // Reset during hold with owner 7
    cyc(1'b1, 10'b0010000000, '0, '0);
    cyc(1'b1, 10'b0010000000, '0, '0);
    chk("g7_sel", 32'(sel), 32'd7);
    cyc(1'b0, '1, '1, '1);
    chk("rst_hold_grt", 32'(grt), 32'h0);
    chk("rst_hold_busy", 32'(busy), 32'h0);
    chk("rst_hold_err", 32'(err), 32'h0);
    cyc(1'b1, 10'b1000000001, '0, '0);
    chk("post_rst_sel", 32'(sel), 32'd0);
    chk("post_rst_grt", 32'(grt), 32'b0000000001);
    cyc(1'b1, '0, '0, '0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 79) != 0);
      rq = N'($urandom) & N'($urandom);
      vl = N'($urandom) & N'($urandom) & N'($urandom);
      ls = N'($urandom);
      cyc(r, rq, vl, ls);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
